// File: rtl/divider_pkg.sv
// divider_pkg: shared state encoding and sizing helpers for the divide sequencer.
package divider_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, ITER, QUOT, REM, DONE} div_state_t;

    localparam int DIV_WIDTH = 8;

    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/div_iter_counter.sv
// div_iter_counter: iteration down-counter; loads WIDTH-1, decrements to zero and holds there.
module div_iter_counter
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = cnt_w(WIDTH)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= CNT_W'(WIDTH - 1);
        else if (dec && count != '0)
            count <= count - CNT_W'(1);
    end

    assign zero = count == '0;

endmodule

// File: rtl/divider_sequencer.sv
// divider_sequencer: control FSM sequencing one restoring divide across the bitslice array.
// Only STORE_ACC and DIVL_P are Mealy (follow ACC_Cout during ITER); all else is Moore.
module divider_sequencer
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic Clock,
    input  logic nReset,
    input  logic Start,
    input  logic SignedOp,
    input  logic Op1Sign,
    input  logic Op2Sign,
    input  logic Op2Zero,
    input  logic ACC_Cout,
    output logic LOAD_DIVL,
    output logic LOAD_ACC,
    output logic LOAD_DIVH,
    output logic INV_OP1,
    output logic OP1_INV_Cin,
    output logic INV_OP2,
    output logic OP2_INV_Cin,
    output logic ACC_Cin,
    output logic STORE_ACC,
    output logic DIVL_P,
    output logic STORE_QUOT,
    output logic INV_RESULT,
    output logic RESULT_INV_Cin,
    output logic STORE_REM,
    output logic INV_REM,
    output logic Busy,
    output logic Done,
    output logic DivByZero
);

    localparam int CNT_W = cnt_w(WIDTH);

    div_state_t state, next_state;
    logic s1, s2;
    logic cnt_zero;
    logic accept;

    assign accept = state == IDLE && Start;

    div_iter_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_counter (
        .clk   (Clock),
        .rst_n (nReset),
        .load  (state == LOAD),
        .dec   (state == ITER),
        .zero  (cnt_zero)
    );

    // Operand signs are captured once at acceptance so the bus may change mid-divide.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state     <= IDLE;
            s1        <= 1'b0;
            s2        <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                s1        <= SignedOp & Op1Sign;
                s2        <= SignedOp & Op2Sign;
                DivByZero <= 1'b0;
            end else if (state == LOAD && Op2Zero) begin
                DivByZero <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state     = state;
        LOAD_DIVL      = 1'b0;
        LOAD_ACC       = 1'b0;
        LOAD_DIVH      = 1'b0;
        INV_OP1        = 1'b0;
        OP1_INV_Cin    = 1'b0;
        INV_OP2        = 1'b0;
        OP2_INV_Cin    = 1'b0;
        ACC_Cin        = 1'b0;
        STORE_ACC      = 1'b0;
        DIVL_P         = 1'b0;
        STORE_QUOT     = 1'b0;
        INV_RESULT     = 1'b0;
        RESULT_INV_Cin = 1'b0;
        STORE_REM      = 1'b0;
        INV_REM        = 1'b0;
        Done           = 1'b0;
        case (state)
            IDLE: next_state = Start ? LOAD : IDLE;
            LOAD: begin
                LOAD_DIVL   = 1'b1;
                LOAD_ACC    = 1'b1;
                LOAD_DIVH   = 1'b1;
                INV_OP1     = s1;
                OP1_INV_Cin = s1;
                INV_OP2     = s2;
                OP2_INV_Cin = s2;
                next_state  = Op2Zero ? DONE : ITER;
            end
            ITER: begin
                ACC_Cin    = 1'b1;
                STORE_ACC  = ACC_Cout;
                DIVL_P     = ACC_Cout;
                next_state = cnt_zero ? QUOT : ITER;
            end
            QUOT: begin
                STORE_QUOT     = 1'b1;
                INV_RESULT     = s1 ^ s2;
                RESULT_INV_Cin = s1 ^ s2;
                next_state     = REM;
            end
            REM: begin
                STORE_REM  = 1'b1;
                INV_REM    = s1;
                next_state = DONE;
            end
            DONE: begin
                Done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign Busy = state != IDLE;

endmodule

// File: tb/tb_divider_sequencer.sv
// tb_divider_sequencer: scoreboard bench; the driver pushes per-cycle expected control vectors
// derived from plain arithmetic division, a negedge monitor pops and compares them.
module tb_divider_sequencer;

    localparam int W = 8;

    logic clk = 1'b0;
    logic nReset, Start, SignedOp, Op1Sign, Op2Sign, Op2Zero, ACC_Cout;
    logic LOAD_DIVL, LOAD_ACC, LOAD_DIVH, INV_OP1, OP1_INV_Cin, INV_OP2, OP2_INV_Cin;
    logic ACC_Cin, STORE_ACC, DIVL_P, STORE_QUOT, INV_RESULT, RESULT_INV_Cin;
    logic STORE_REM, INV_REM, Busy, Done, DivByZero;

    typedef struct {
        logic [17:0] v;
        string       tag;
    } item_t;

    item_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  dz_exp = 1'b0;

    always #5 clk = ~clk;

    divider_sequencer #(.WIDTH(W)) dut (
        .Clock(clk), .nReset(nReset), .Start(Start), .SignedOp(SignedOp),
        .Op1Sign(Op1Sign), .Op2Sign(Op2Sign), .Op2Zero(Op2Zero), .ACC_Cout(ACC_Cout),
        .LOAD_DIVL(LOAD_DIVL), .LOAD_ACC(LOAD_ACC), .LOAD_DIVH(LOAD_DIVH),
        .INV_OP1(INV_OP1), .OP1_INV_Cin(OP1_INV_Cin), .INV_OP2(INV_OP2),
        .OP2_INV_Cin(OP2_INV_Cin), .ACC_Cin(ACC_Cin), .STORE_ACC(STORE_ACC),
        .DIVL_P(DIVL_P), .STORE_QUOT(STORE_QUOT), .INV_RESULT(INV_RESULT),
        .RESULT_INV_Cin(RESULT_INV_Cin), .STORE_REM(STORE_REM), .INV_REM(INV_REM),
        .Busy(Busy), .Done(Done), .DivByZero(DivByZero)
    );

    function automatic logic [17:0] outs();
        return {LOAD_DIVL, LOAD_ACC, LOAD_DIVH, INV_OP1, OP1_INV_Cin, INV_OP2, OP2_INV_Cin,
                ACC_Cin, STORE_ACC, DIVL_P, STORE_QUOT, INV_RESULT, RESULT_INV_Cin,
                STORE_REM, INV_REM, Busy, Done, DivByZero};
    endfunction

    task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [17:0] v, input string tag);
        item_t it;
        it.v = v;
        it.tag = tag;
        exp_q.push_back(it);
    endtask

    // Monitor: any cycle with activity (everything but the sticky DivByZero) consumes one entry.
    initial begin
        logic [17:0] act;
        item_t e;
        forever begin
            @(negedge clk);
            act = outs();
            if (act[17:1] != '0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_activity got=%h want=idle t=%0t", act, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e.v) begin
                        errors++;
                        $display("FAIL %s got=%h want=%h t=%0t", e.tag, act, e.v, $time);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        ACC_Cout = 1'($urandom);
    endtask

    task automatic scramble();
        SignedOp = 1'($urandom);
        Op1Sign  = 1'($urandom);
        Op2Sign  = 1'($urandom);
        Op2Zero  = 1'($urandom);
    endtask

    task automatic gap(input int n);
        Start = 1'b0;
        repeat (n) step();
    endtask

    // Entered at the start of an IDLE cycle; returns at the start of the following IDLE cycle.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b, input logic sg,
                           input logic keep, input int abort_at);
        logic s1e, s2e, zero;
        logic [7:0] ma, mb, q;
        int n_iter;
        chk("idle_busy", {17'b0, Busy}, 18'b0);
        chk("idle_divbyzero", {17'b0, DivByZero}, {17'b0, dz_exp});
        s1e  = sg & a[7];
        s2e  = sg & b[7];
        ma   = s1e ? -a : a;
        mb   = s2e ? -b : b;
        zero = b == 8'd0;
        q    = zero ? 8'd0 : ma / mb;
        Start = 1'b1; SignedOp = sg; Op1Sign = a[7]; Op2Sign = b[7]; Op2Zero = zero;
        push({3'b111, s1e, s1e, s2e, s2e, 8'b0, 3'b100}, "load");
        n_iter = (abort_at >= 0) ? abort_at : W;
        if (zero) begin
            push({15'b0, 3'b111}, "done_div0");
        end else begin
            for (int i = 0; i < n_iter; i++)
                push({7'b0, 1'b1, q[W-1-i], q[W-1-i], 5'b0, 3'b100}, $sformatf("iter%0d", i));
            if (abort_at < 0) begin
                push({10'b0, 1'b1, s1e ^ s2e, s1e ^ s2e, 2'b0, 3'b100}, "quot");
                push({13'b0, 1'b1, s1e, 3'b100}, "rem");
                push({15'b0, 3'b110}, "done");
            end
        end
        step();
        if (!keep) Start = 1'b0;
        if (zero) begin
            step();
            scramble();
            dz_exp = 1'b1;
            step();
            return;
        end
        dz_exp = 1'b0;
        for (int i = 0; i < W; i++) begin
            step();
            scramble();
            ACC_Cout = q[W-1-i];
            if (i == abort_at) begin
                nReset = 1'b0;
                #1;
                chk("abort_outputs_zero", outs(), 18'b0);
                Start = 1'b0;
                step();
                chk("abort_held_zero", outs(), 18'b0);
                nReset = 1'b1;
                step();
                return;
            end
        end
        repeat (4) step();
    endtask

    initial begin
        nReset = 1'b0; Start = 1'b0; SignedOp = 1'b0; Op1Sign = 1'b0; Op2Sign = 1'b0;
        Op2Zero = 1'b0; ACC_Cout = 1'b0;
        repeat (2) step();
        chk("reset_outputs", outs(), 18'b0);
        nReset = 1'b1;
        step();
        chk("post_reset_idle", outs(), 18'b0);
        run_div(8'd100, 8'd7, 1'b0, 1'b0, -1);
        run_div(8'd156, 8'd7, 1'b1, 1'b0, -1);
        run_div(8'd156, 8'd249, 1'b1, 1'b0, -1);
        run_div(8'd100, 8'd0, 1'b0, 1'b0, -1);
        gap(3);
        run_div(8'd100, 8'd7, 1'b0, 1'b1, -1);
        run_div(8'd200, 8'd9, 1'b1, 1'b1, -1);
        run_div(8'd50, 8'd3, 1'b0, 1'b0, -1);
        run_div(8'd100, 8'd7, 1'b1, 1'b0, 3);
        gap(1);
        run_div(8'd77, 8'd5, 1'b0, 1'b0, 0);
        gap(2);
        for (int k = 0; k < 24; k++) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            run_div(a, b, 1'($urandom), 1'b0, -1);
            gap($urandom_range(0, 2));
        end
        repeat (3) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d want=0 pending", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "timeout");
    end

endmodule
